// File: rtl/crossing_turner.sv
// Crossing manoeuvre responder: on request from the line-follower controller it owns
// the motors, runs a timed straight/left/right/U-turn sequence and hands control back.
module crossing_turner #(
   parameter int PERIOD         = 2_000_000,
   parameter int FWD_STEPS      = 8,
   parameter int SPIN_MIN_STEPS = 5,
   parameter int TIMEOUT_STEPS  = 100
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       turn_crossing_start,
   input  logic [1:0] turn_dir,
   input  logic       sensor_m,
   output logic       line_follower_start,
   output logic       busy,
   output logic       turn_error,
   output logic       motor_l_reset,
   output logic       motor_l_direction,
   output logic       motor_r_reset,
   output logic       motor_r_direction
);

   localparam logic [2:0] S_IDLE       = 3'd0;
   localparam logic [2:0] S_FORWARD    = 3'd1;
   localparam logic [2:0] S_SPIN_LEAVE = 3'd2;
   localparam logic [2:0] S_SPIN_FIND  = 3'd3;
   localparam logic [2:0] S_DONE       = 3'd4;

   localparam logic [1:0] DIR_STRAIGHT = 2'b00;
   localparam logic [1:0] DIR_RIGHT    = 2'b10;
   localparam logic [1:0] DIR_UTURN    = 2'b11;

   logic [2:0]  state_reg, state_next;
   logic [20:0] cycle_reg, step_reg;
   logic [1:0]  dir_reg, dir_next;
   logic [1:0]  find_reg, find_next;
   logic        error_reg, error_next;
   logic        sensor_reg;
   logic        step_tick;
   logic [20:0] step_inc;
   logic        fwd_done;
   logic        spin_timeout;

   // Step limits fire on the edge where the step counter is about to reach them,
   // so a limit of N steps occupies exactly N*PERIOD cycles.
   assign step_tick    = (cycle_reg == 21'(PERIOD - 1));
   assign step_inc     = step_reg + 21'd1;
   assign fwd_done     = step_tick && (step_inc == 21'(FWD_STEPS));
   assign spin_timeout = step_tick && (step_inc == 21'(TIMEOUT_STEPS));

   always_comb begin
      state_next = state_reg;
      dir_next   = dir_reg;
      find_next  = find_reg;
      error_next = error_reg;
      case (state_reg)
         S_IDLE: begin
            if (turn_crossing_start) begin
               dir_next   = turn_dir;
               error_next = 1'b0;
               find_next  = 2'd0;
               state_next = S_FORWARD;
            end
         end
         S_FORWARD: begin
            if (fwd_done)
               state_next = (dir_reg == DIR_STRAIGHT) ? S_DONE : S_SPIN_LEAVE;
         end
         S_SPIN_LEAVE: begin
            if (spin_timeout) begin
               error_next = 1'b1;
               state_next = S_DONE;
            end else if (step_reg >= 21'(SPIN_MIN_STEPS) && sensor_reg) begin
               state_next = S_SPIN_FIND;
            end
         end
         S_SPIN_FIND: begin
            if (spin_timeout) begin
               error_next = 1'b1;
               state_next = S_DONE;
            end else if (!sensor_reg) begin
               find_next = find_reg + 2'd1;
               // A U-turn has to sweep past the line it is crossing before the real one.
               if (dir_reg == DIR_UTURN && find_reg == 2'd0)
                  state_next = S_SPIN_LEAVE;
               else
                  state_next = S_DONE;
            end
         end
         S_DONE: begin
            if (!turn_crossing_start)
               state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg  <= S_IDLE;
         cycle_reg  <= '0;
         step_reg   <= '0;
         dir_reg    <= DIR_STRAIGHT;
         find_reg   <= '0;
         error_reg  <= 1'b0;
         sensor_reg <= 1'b1;
      end else begin
         state_reg  <= state_next;
         dir_reg    <= dir_next;
         find_reg   <= find_next;
         error_reg  <= error_next;
         sensor_reg <= sensor_m;
         if (state_next != state_reg) begin
            cycle_reg <= '0;
            step_reg  <= '0;
         end else if (step_tick) begin
            cycle_reg <= '0;
            step_reg  <= step_inc;
         end else begin
            cycle_reg <= cycle_reg + 21'd1;
         end
      end
   end

   always_comb begin
      motor_l_reset     = 1'b1;
      motor_r_reset     = 1'b1;
      motor_l_direction = 1'b0;
      motor_r_direction = 1'b0;
      case (state_reg)
         S_FORWARD: begin
            motor_l_reset     = 1'b0;
            motor_r_reset     = 1'b0;
            motor_l_direction = 1'b1;
         end
         S_SPIN_LEAVE, S_SPIN_FIND: begin
            motor_l_reset     = 1'b0;
            motor_r_reset     = 1'b0;
            motor_l_direction = (dir_reg == DIR_RIGHT);
            motor_r_direction = (dir_reg == DIR_RIGHT);
         end
         default: ;
      endcase
   end

   assign busy                = (state_reg != S_IDLE);
   assign line_follower_start = (state_reg == S_DONE);
   assign turn_error          = error_reg;

endmodule

// File: tb/tb_crossing_turner.sv
// Self-checking bench for crossing_turner: directed manoeuvres with fixed cycle
// expectations plus a randomized controller, all compared against a behavioural model.
module tb_crossing_turner;

   localparam int PERIOD  = 10;
   localparam int FWD     = 2;
   localparam int SPINMIN = 1;
   localparam int TMO     = 6;

   logic       clk = 1'b0;
   logic       reset;
   logic       turn_crossing_start;
   logic [1:0] turn_dir;
   logic       sensor_m;
   logic       line_follower_start, busy, turn_error;
   logic       motor_l_reset, motor_l_direction, motor_r_reset, motor_r_direction;

   int n_checks = 0;
   int n_errors = 0;

   // Behavioural model: phase 0 idle, 1 forward, 2 leave line, 3 find line, 4 done.
   int         m_phase   = 0;
   int         m_elapsed = 0;
   logic [1:0] m_dir     = 2'b00;
   int         m_finds   = 0;
   logic       m_err     = 1'b0;
   logic       m_sens    = 1'b1;

   crossing_turner #(
      .PERIOD(PERIOD), .FWD_STEPS(FWD), .SPIN_MIN_STEPS(SPINMIN), .TIMEOUT_STEPS(TMO)
   ) dut (
      .clk(clk),
      .reset(reset),
      .turn_crossing_start(turn_crossing_start),
      .turn_dir(turn_dir),
      .sensor_m(sensor_m),
      .line_follower_start(line_follower_start),
      .busy(busy),
      .turn_error(turn_error),
      .motor_l_reset(motor_l_reset),
      .motor_l_direction(motor_l_direction),
      .motor_r_reset(motor_r_reset),
      .motor_r_direction(motor_r_direction)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [6:0] dut_vec();
      return {line_follower_start, busy, turn_error,
              motor_l_reset, motor_l_direction, motor_r_reset, motor_r_direction};
   endfunction

   function automatic logic [6:0] model_vec();
      logic lr, ld, rr, rd;
      lr = 1'b1; ld = 1'b0; rr = 1'b1; rd = 1'b0;
      if (m_phase == 1) begin
         lr = 1'b0; rr = 1'b0; ld = 1'b1;
      end else if (m_phase == 2 || m_phase == 3) begin
         lr = 1'b0; rr = 1'b0;
         ld = (m_dir == 2'b10);
         rd = (m_dir == 2'b10);
      end
      return {m_phase == 4, m_phase != 0, m_err, lr, ld, rr, rd};
   endfunction

   task automatic model_step();
      int  nxt;
      bool_dummy: begin end
      if (!reset) begin
         m_phase = 0; m_elapsed = 0; m_dir = 2'b00; m_finds = 0; m_err = 1'b0; m_sens = 1'b1;
         return;
      end
      nxt = m_phase;
      case (m_phase)
         0: if (turn_crossing_start) begin
               m_dir = turn_dir; m_err = 1'b0; m_finds = 0; nxt = 1;
            end
         1: if (m_elapsed + 1 == FWD * PERIOD) nxt = (m_dir == 2'b00) ? 4 : 2;
         2: if (m_elapsed + 1 == TMO * PERIOD) begin
               m_err = 1'b1; nxt = 4;
            end else if (m_elapsed / PERIOD >= SPINMIN && m_sens) begin
               nxt = 3;
            end
         3: if (m_elapsed + 1 == TMO * PERIOD) begin
               m_err = 1'b1; nxt = 4;
            end else if (!m_sens) begin
               nxt = (m_dir == 2'b11 && m_finds == 0) ? 2 : 4;
               m_finds++;
            end
         default: if (!turn_crossing_start) nxt = 0;
      endcase
      m_elapsed = (nxt != m_phase) ? 0 : m_elapsed + 1;
      m_phase   = nxt;
      m_sens    = sensor_m;
   endtask

   task automatic tick(input logic r, input logic s, input logic [1:0] d, input logic sn);
      reset = r; turn_crossing_start = s; turn_dir = d; sensor_m = sn;
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("outs", 32'(dut_vec()), 32'(model_vec()));
   endtask

   // One full manoeuvre; sample index k counts cycles from the first forward cycle.
   task automatic run_turn(input string name, input logic [1:0] d,
                           input int a1, input int b1, input int a2, input int b2,
                           input int hold, input int exp_done, input int exp_spin,
                           input logic [3:0] pat, input logic exp_err);
      int   done_at, spin;
      logic sn;
      done_at = -1;
      spin    = 0;
      tick(1'b1, 1'b1, d, 1'b0);
      for (int k = 0; k < 300; k++) begin
         if (line_follower_start) begin
            done_at = k;
            break;
         end
         if ({motor_l_reset, motor_l_direction, motor_r_reset, motor_r_direction} == pat)
            spin++;
         sn = (k >= a1 && k < b1) || (k >= a2 && k < b2);
         tick(1'b1, (k < hold), d, sn);
      end
      check({name, "_done_at"}, 32'(done_at), 32'(exp_done));
      check({name, "_spin"}, 32'(spin), 32'(exp_spin));
      check({name, "_err"}, 32'(turn_error), 32'(exp_err));
      tick(1'b1, 1'b0, d, 1'b0);
      check({name, "_idle"}, 32'(busy), 32'd0);
      $display("turn %s: dir=%0d done_at=%0d spin=%0d err=%0b", name, d, done_at, spin, turn_error);
   endtask

   initial begin
      int   run_len;
      logic sv, s;
      int   prev_phase;

      for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 2'b00, 1'b0);
      tick(1'b1, 1'b0, 2'b00, 1'b0);
      check("reset_idle", 32'(dut_vec()), 32'h0A);

      run_turn("straight", 2'b00, 0, 0, 0, 0, 1000, 20, 0, 4'b0000, 1'b0);
      run_turn("left", 2'b01, 35, 50, 0, 0, 1000, 52, 32, 4'b0000, 1'b0);
      run_turn("uturn", 2'b11, 25, 35, 45, 55, 1000, 57, 37, 4'b0000, 1'b0);
      run_turn("right_tmo", 2'b10, 0, 0, 0, 0, 1000, 80, 60, 4'b0101, 1'b1);
      run_turn("drop_start", 2'b00, 0, 0, 0, 0, 5, 20, 0, 4'b0000, 1'b0);

      // Reset while searching for the line must abort straight back to idle.
      tick(1'b1, 1'b1, 2'b01, 1'b0);
      for (int k = 0; k < 36; k++) tick(1'b1, 1'b1, 2'b01, (k >= 25));
      check("in_find_busy", 32'(busy), 32'd1);
      tick(1'b0, 1'b1, 2'b01, 1'b1);
      check("rst_mid", 32'(dut_vec()), 32'h0A);
      tick(1'b1, 1'b0, 2'b00, 1'b1);
      check("rst_mid_idle", 32'(busy), 32'd0);

      run_len = 0;
      sv = 1'b0;
      s  = 1'b0;
      for (int t = 0; t < 5000; t++) begin
         if (m_phase == 4) s = 1'b0;
         else if (m_phase == 0) s = ($urandom_range(0, 2) == 0);
         else s = ($urandom_range(0, 9) != 0);
         if (run_len == 0) begin
            sv = ~sv;
            run_len = $urandom_range(1, 20);
         end
         run_len--;
         prev_phase = m_phase;
         tick(($urandom_range(0, 399) != 0), s, 2'($urandom_range(0, 3)), sv);
         if (m_phase == 4 && prev_phase != 4)
            $display("random turn: dir=%0d err=%0b at %0t", m_dir, m_err, $time);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/crossing_turner.md
Name: crossing_turner

Overview:
- Responder side of the line-follower controller's crossing handshake.
- The controller raises turn_crossing_start at a crossing. This block then takes over the motor commands and carries out a timed manoeuvre: straight, left, right or U-turn.
- When the manoeuvre is finished, the block raises line_follower_start to hand control back to the controller.
- Sits beside the controller. A top-level mux routes this block's motor outputs to the PWM motor drivers while busy=1.

Parameters:
- PERIOD, 2_000_000, clock cycles per motor step (20 ms at 100 MHz). Internal step counter is 21 bits.
- FWD_STEPS, 8, steps driven forward to clear the crossing before any rotation.
- SPIN_MIN_STEPS, 5, minimum rotation steps before line loss is accepted (prevents re-acquiring the same line).
- TIMEOUT_STEPS, 100, maximum steps spent in any single spin state before aborting.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- turn_crossing_start  in  1  request from controller; level, held until line_follower_start seen
- turn_dir  in  2  00 straight, 01 left, 10 right, 11 U-turn; sampled only on request acceptance
- sensor_m  in  1  middle line sensor; 0 = on black line
- line_follower_start  out  1  done/handback to controller
- busy  out  1  block owns the motors
- turn_error  out  1  last manoeuvre ended by timeout
- motor_l_reset  out  1  1 = left motor stopped
- motor_l_direction  out  1  left motor direction
- motor_r_reset  out  1  1 = right motor stopped
- motor_r_direction  out  1  right motor direction

Behaviour:
- Reset (reset==0 at a clk edge):
  - State goes to IDLE; step and cycle counters cleared; latched direction = 00.
  - Outputs: line_follower_start=0, busy=0, turn_error=0, motor_l_reset=1, motor_r_reset=1, both directions=0.
  - A reset mid-manoeuvre aborts immediately.
- sensor_m is registered once (1-cycle delay) before use.
- Motor outputs are Moore, decoded from state only:
  - stopped: both resets=1, dirs=0
  - forward: l_dir=1, r_dir=0, both resets=0
  - spin left: both dirs=0, both resets=0
  - spin right: both dirs=1, both resets=0
- Step timing:
  - Cycle counter counts 0..PERIOD-1.
  - At PERIOD-1 it wraps to 0 and the step counter increments.
  - Both counters clear on every state change.
- States and transitions:
  - IDLE: busy=0, motors stopped. If turn_crossing_start==1, latch turn_dir, clear turn_error and the find counter, then go to FORWARD on the next edge. busy=1 from that cycle on.
  - FORWARD: drive forward. When step counter reaches FWD_STEPS: if latched dir==00 go to DONE, otherwise go to SPIN_LEAVE.
  - SPIN_LEAVE: spin right if dir==10, otherwise spin left. Go to SPIN_FIND once step counter >= SPIN_MIN_STEPS and registered sensor_m==1.
  - SPIN_FIND: same spin direction. When registered sensor_m==0, increment the find counter. Then:
    - dir==11 and find counter was 0: go back to SPIN_LEAVE (U-turn passes one line first).
    - otherwise: go to DONE.
  - Timeout: in SPIN_LEAVE or SPIN_FIND, if step counter reaches TIMEOUT_STEPS, set turn_error=1 and go to DONE.
  - DONE: motors stopped, line_follower_start=1, busy=1. When turn_crossing_start==0, go to IDLE; line_follower_start drops in that same transition. turn_error holds until the next accepted request.
- Handshake rules:
  - A request is accepted only in IDLE.
  - turn_crossing_start falling before DONE is ignored; the manoeuvre completes.
  - turn_crossing_start held high after returning to IDLE is treated as a new request. The controller must drop it within 1 cycle of seeing line_follower_start.
- Latency: request to first motor drive = 1 cycle; DONE to line_follower_start = 0 cycles (Moore output in DONE).

Test Plan (all with PERIOD=10, FWD_STEPS=2, SPIN_MIN_STEPS=1, TIMEOUT_STEPS=6):
- Reset low for 3 cycles, then high with start=0 -> motors stopped, busy=0, line_follower_start=0, turn_error=0.
- Start with dir=00 -> forward (l_dir=1, r_dir=0) for exactly 20 cycles, then line_follower_start=1. Drop start -> IDLE one cycle later.
- Start with dir=01; sensor_m=1 at cycle 35, then 0 at cycle 50 -> forward for 20 cycles, spin left until cycle 52 (1-cycle sensor delay plus transition), then DONE with turn_error=0.
- Start with dir=11; sensor_m pattern 1,0,1,0 -> two line finds before DONE; spin left throughout.
- Start with dir=10; sensor_m stuck at 0 -> spin right (both dirs=1) for 60 cycles, then turn_error=1 and line_follower_start=1.
- Reset asserted during SPIN_FIND -> all outputs return to reset values on the next edge. A start pulse that drops during FORWARD still completes the manoeuvre.
